mhsa_stage_seq: RTL and testbench
=================================

Name: mhsa_stage_seq

Overview:
- Parametrised sequencer and SRAM-bank arbiter for the MHSA accelerator. Generalises the fixed seven-state top-level FSM.
- Runs up to NUM_STAGES compute stages in index order (linear, qkmm, scale, softmax, attmm, pool, ...), skipping any stage whose bit in a run-time enable mask is clear.
- Routes the active stage's write-enable, address and write-data onto NUM_BARS unified SRAM bars. Adds an inter-stage idle gap and a per-stage timeout watchdog.

Parameters:
- WIDTH, 64: SRAM data width.
- ADDR_W, 32: SRAM address width.
- NUM_STAGES, 6: number of stage slots (1..16).
- NUM_BARS, 4: number of SRAM bars (1..8).
- TIMEOUT_W, 20: width of the watchdog counter and timeout_cyc.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level run request.
- done  out  1  run complete.
- error  out  1  stage timed out.
- stage_en  in  NUM_STAGES  stage enable mask, sampled at start.
- timeout_cyc  in  TIMEOUT_W  per-stage cycle limit; 0 disables the watchdog.
- cur_stage  out  4  index of the active stage.
- stage_start  out  NUM_STAGES  one-hot level start to the stages.
- stage_done  in  NUM_STAGES  stage completion flags.
- st_we  in  NUM_STAGES*NUM_BARS  per-stage per-bar write enable; bit index s*NUM_BARS+b.
- st_addr  in  NUM_STAGES*NUM_BARS*ADDR_W  per-stage per-bar address; slice index (s*NUM_BARS+b).
- st_din  in  NUM_STAGES*NUM_BARS*WIDTH  per-stage per-bar write data; same slicing.
- bar_we  out  NUM_BARS  bar write enables.
- bar_addr  out  NUM_BARS*ADDR_W  bar addresses.
- bar_din  out  NUM_BARS*WIDTH  bar write data.
- Bar read data is broadcast to the stages outside this block.

Behaviour:
- Single clock domain: all state updates on posedge clk; rst is sampled on the clock edge and is active-high.
- Reset: state=IDLE; mask_q=0; cur_stage=0; wd_cnt=0. Outputs: done=0, error=0, stage_start=0, bar_we=0, bar_addr=0, bar_din=0.
- Reset mid-run: same as above on the next edge. No stage_start stays asserted.
- States: IDLE, RUN, GAP, DONE, ERR.
- IDLE
  - On start=1, latch mask_q=stage_en.
  - If mask_q is zero, go to DONE next cycle.
  - Otherwise cur_stage = lowest set index; go to RUN.
- RUN
  - stage_start[cur_stage]=1; all other bits 0.
  - For each bar b, drive bar_we/bar_addr/bar_din combinationally from st_*[cur_stage][b].
  - wd_cnt increments every cycle.
  - stage_done[cur_stage]=1: clear mask_q[cur_stage], clear wd_cnt, go to GAP.
  - stage_done bits of non-current stages are ignored.
- GAP
  - Exactly one cycle. stage_start=0; bars idle.
  - cur_stage advances to the next set bit of mask_q above the current index. Go to RUN, or to DONE if none remain.
- DONE: done=1. Hold while start=1; go to IDLE when start=0.
- Watchdog
  - In RUN, if timeout_cyc!=0 and wd_cnt==timeout_cyc-1 with no stage_done that cycle, go to ERR.
  - If stage_done and the timeout coincide, done wins.
- ERR: error=1; stage_start=0; bars idle; cur_stage holds the failed index. Go to IDLE when start=0.
- Bars idle means bar_we=0, bar_addr=0, bar_din=0. Bars are idle in every state except RUN.
- done and error are registered state decodes and are never both 1.
- Latency
  - start to first stage_start: 1 cycle.
  - stage_done to the next stage_start: 2 cycles (the GAP cycle).
  - Last stage_done to done: 2 cycles.
- stage_en changes after start are ignored until the next IDLE.

Test Plan:
- All stages enabled: stage_en=6'b111111, each stage asserts done 10 cycles after its start. Required: stage_start steps 0..5 one-hot with a 1-cycle zero gap between stages; done=1 exactly 2 cycles after stage 5's done.
- Skip mask: stage_en=6'b100101. Required: only stages 0, 2 and 5 are started, in that order; cur_stage sequence is 0, 2, 5.
- Bar routing in stage 2: st_we[2][1]=1, st_addr=0x40, st_din=0xDEAD_BEEF, with other stages driving junk. Required: bar_we[1]=1, bar_addr[1]=0x40, bar_din[1]=0xDEADBEEF; all bars read 0 during GAP.
- Watchdog fire: timeout_cyc=5, stage 0 never done. Required: error=1 at cycle 6 after start, stage_start=0, bars idle; error clears and state returns to IDLE one cycle after start=0.
- Watchdog tie and empty mask: stage_done on the 5th RUN cycle with timeout_cyc=5 → normal advance, no error. stage_en=0 → done=1 with no stage_start ever asserted.
- Reset mid-run: assert rst during stage 3 RUN. Required: next edge gives stage_start=0, bar_we=0, done=0, error=0; a fresh start restarts from the lowest enabled stage.

Source files
------------

// File: rtl/mhsa_stage_seq.sv
// mhsa_stage_seq: enable-masked stage sequencer with SRAM bar routing and a per-stage watchdog.
module mhsa_stage_seq #(
  parameter int WIDTH      = 64,
  parameter int ADDR_W     = 32,
  parameter int NUM_STAGES = 6,
  parameter int NUM_BARS   = 4,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic                                  done,
  output logic                                  error,
  input  logic [NUM_STAGES-1:0]                 stage_en,
  input  logic [TIMEOUT_W-1:0]                  timeout_cyc,
  output logic [3:0]                            cur_stage,
  output logic [NUM_STAGES-1:0]                 stage_start,
  input  logic [NUM_STAGES-1:0]                 stage_done,
  input  logic [NUM_STAGES*NUM_BARS-1:0]        st_we,
  input  logic [NUM_STAGES*NUM_BARS*ADDR_W-1:0] st_addr,
  input  logic [NUM_STAGES*NUM_BARS*WIDTH-1:0]  st_din,
  output logic [NUM_BARS-1:0]                   bar_we,
  output logic [NUM_BARS*ADDR_W-1:0]            bar_addr,
  output logic [NUM_BARS*WIDTH-1:0]             bar_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [3:0]            cur_q, cur_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
  logic [NUM_STAGES-1:0] cur_oh;
  logic                  cur_done;
  logic                  wd_hit;
  logic [4:0]            nxt;

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [4:0] next_set(input logic [NUM_STAGES-1:0] m, input int lo);
    logic [4:0] r;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Current-stage decode
  always_comb begin
    cur_oh = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      cur_oh[s] = (cur_q == 4'(s));
    end
  end

  assign cur_done = |(cur_oh & stage_done);
  assign wd_hit   = (timeout_cyc != '0) && (wd_q == timeout_cyc - TIMEOUT_W'(1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    wd_d    = wd_q;
    nxt     = '0;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (start) begin
          mask_d = stage_en;
          nxt    = next_set(stage_en, 0);
          if (nxt[4]) begin
            cur_d   = nxt[3:0];
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (cur_done) begin
          // completion beats a coincident watchdog expiry
          mask_d  = mask_q & ~cur_oh;
          wd_d    = '0;
          state_d = S_GAP;
        end else if (wd_hit) begin
          wd_d    = '0;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      S_GAP: begin
        nxt = next_set(mask_q, int'(cur_q) + 1);
        if (nxt[4]) begin
          cur_d   = nxt[3:0];
          state_d = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      S_ERR: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cur_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      wd_q    <= wd_d;
    end
  end

  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);
  assign cur_stage   = cur_q;
  assign stage_start = (state_q == S_RUN) ? cur_oh : '0;

  // Bar routing: only the running stage reaches the bars
  always_comb begin
    bar_we   = '0;
    bar_addr = '0;
    bar_din  = '0;
    if (state_q == S_RUN) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (cur_oh[s]) begin
          for (int b = 0; b < NUM_BARS; b++) begin
            bar_we[b]                   = st_we[s*NUM_BARS+b];
            bar_addr[b*ADDR_W +: ADDR_W] = st_addr[(s*NUM_BARS+b)*ADDR_W +: ADDR_W];
            bar_din[b*WIDTH +: WIDTH]    = st_din[(s*NUM_BARS+b)*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mhsa_stage_seq.sv
// tb_mhsa_stage_seq: directed scoreboard bench for the stage sequencer.
module tb_mhsa_stage_seq;

  localparam int NS = 6;
  localparam int NB = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TW = 20;

  logic              clk;
  logic              rst;
  logic              start;
  logic              done;
  logic              error;
  logic [NS-1:0]     stage_en;
  logic [TW-1:0]     timeout_cyc;
  logic [3:0]        cur_stage;
  logic [NS-1:0]     stage_start;
  logic [NS-1:0]     stage_done;
  logic [NS*NB-1:0]  st_we;
  logic [NS*NB*AW-1:0] st_addr;
  logic [NS*NB*DW-1:0] st_din;
  logic [NB-1:0]     bar_we;
  logic [NB*AW-1:0]  bar_addr;
  logic [NB*DW-1:0]  bar_din;

  mhsa_stage_seq #(
    .WIDTH(DW), .ADDR_W(AW), .NUM_STAGES(NS), .NUM_BARS(NB), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .error(error),
    .stage_en(stage_en), .timeout_cyc(timeout_cyc), .cur_stage(cur_stage),
    .stage_start(stage_start), .stage_done(stage_done),
    .st_we(st_we), .st_addr(st_addr), .st_din(st_din),
    .bar_we(bar_we), .bar_addr(bar_addr), .bar_din(bar_din)
  );

  // event kinds: 0 stage start, 1 done rise, 2 error rise, 3 error fall,
  // 4 done fall, 5 bar write rise, 6 reset edge
  typedef struct {
    int              kind;
    logic [31:0]     val;
    int              cyc;
    logic [NB*AW-1:0] addr;
    logic [NB*DW-1:0] din;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rst_edge = 1'b0;
  int   dly[NS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  function automatic string kname(input int k);
    case (k)
      0: return "stage_start";
      1: return "done_rise";
      2: return "error_rise";
      3: return "error_fall";
      4: return "done_fall";
      5: return "bar_write";
      default: return "reset_state";
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    e.addr = '0;
    e.din  = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_bar(input int c);
    ev_t e;
    e.kind = 5;
    e.val  = 32'h2;
    e.cyc  = c;
    e.addr = '0;
    e.din  = '0;
    e.addr[1*AW +: AW] = 32'h40;
    e.din[1*DW +: DW]  = 64'hDEAD_BEEF;
    exp_q.push_back(e);
  endtask

  task automatic obs(input int kind, input logic [31:0] val,
                     input logic [NB*AW-1:0] a, input logic [NB*DW-1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got val=0x%0h at cyc=%0d, required no event", kname(kind), val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc || e.addr != a || e.din != d) begin
        failures++;
        $display("FAIL %s: got kind=%0d val=0x%0h cyc=%0d addr=0x%0h din=0x%0h, required kind=%0d val=0x%0h cyc=%0d addr=0x%0h din=0x%0h",
                 kname(e.kind), kind, val, cyc, a, d, e.kind, e.val, e.cyc, e.addr, e.din);
      end
    end
  endtask

  // Monitor: turns output edges into events and compares against the queue.
  initial begin
    logic [NS-1:0] prev_ss;
    logic          prev_done;
    logic          prev_err;
    logic [NB-1:0] prev_bwe;
    prev_ss = '0; prev_done = 1'b0; prev_err = 1'b0; prev_bwe = '0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        checks++;
        if (done === 1'b1 && error === 1'b1) begin
          failures++;
          $display("FAIL done_error_exclusive: got done=%0b error=%0b, required not both 1", done, error);
        end
        if (stage_start === '0) begin
          checks++;
          if (bar_we !== '0 || bar_addr !== '0 || bar_din !== '0) begin
            failures++;
            $display("FAIL bars_idle: got we=0x%0h addr=0x%0h din=0x%0h at cyc=%0d, required all 0",
                     bar_we, bar_addr, bar_din, cyc);
          end
        end
        if (rst_edge) begin
          obs(6, {28'd0, |stage_start, |bar_we, done, error}, '0, '0);
        end else begin
          if (stage_start != '0 && prev_ss == '0)
            obs(0, (32'(stage_start) << 4) | 32'(cur_stage), '0, '0);
          if (bar_we != '0 && prev_bwe == '0)
            obs(5, 32'(bar_we), bar_addr, bar_din);
          if (done && !prev_done) obs(1, 32'd0, '0, '0);
          if (!done && prev_done) obs(4, 32'd0, '0, '0);
          if (error && !prev_err) obs(2, {27'd0, |stage_start, cur_stage}, '0, '0);
          if (!error && prev_err) obs(3, 32'd0, '0, '0);
        end
        prev_ss   = stage_start;
        prev_done = done;
        prev_err  = error;
        prev_bwe  = bar_we;
      end
    end
  end

  // Stage model: each started stage raises its done flag dly[s] cycles after its start.
  initial begin
    logic [NS-1:0] prev_r;
    int            rcnt;
    stage_done = '0;
    prev_r     = '0;
    rcnt       = 0;
    forever begin
      @(negedge clk);
      stage_done = '0;
      if (stage_start != '0) begin
        if (prev_r == '0) rcnt = 0;
        else rcnt++;
        for (int s = 0; s < NS; s++) begin
          if (stage_start[s] && dly[s] != 0 && rcnt == dly[s]) stage_done[s] = 1'b1;
        end
      end
      prev_r = stage_start;
    end
  end

  task automatic start_run(input logic [NS-1:0] en, input logic [TW-1:0] tmo, input bit bar_chk);
    int t;
    @(posedge clk); #1;
    stage_en    = en;
    timeout_cyc = tmo;
    start       = 1'b1;
    t = cyc + 1;
    for (int s = 0; s < NS; s++) begin
      if (en[s]) begin
        push(0, (32'd1 << (4 + s)) | 32'(s), t);
        if (bar_chk && s == 2) push_bar(t);
        t = t + dly[s] + 2;
      end
    end
    push(1, 32'd0, t);
  endtask

  task automatic finish_run(input bit is_err);
    int n;
    n = 0;
    while (!(done || error) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL run_completion: got no done/error within 300 cycles, required one");
    end
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    push(is_err ? 3 : 4, 32'd0, cyc + 1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of stimulus, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; stage_en = '0; timeout_cyc = '0;
    st_we = '0; st_addr = '0; st_din = '0;
    for (int s = 0; s < NS; s++) dly[s] = 10;
    push(6, 32'd0, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // all stages, 10-cycle stages: starts at +1,+13,...,+61, done at +73
    start_run(6'b111111, '0, 1'b0);
    finish_run(1'b0);

    // skip mask, stage_en change after start must be ignored
    for (int s = 0; s < NS; s++) dly[s] = 3;
    start_run(6'b100101, '0, 1'b0);
    @(posedge clk); #1;
    stage_en = 6'b111111;
    finish_run(1'b0);

    // bar routing in stage 2 with junk on all other stages
    for (int i = 0; i < NS*NB; i++) begin
      st_addr[i*AW +: AW] = $urandom();
      st_din[i*DW +: DW]  = {$urandom(), $urandom()};
    end
    st_we = '1;
    for (int b = 0; b < NB; b++) begin
      st_we[2*NB+b]               = (b == 1);
      st_addr[(2*NB+b)*AW +: AW]  = (b == 1) ? 32'h40 : 32'h0;
      st_din[(2*NB+b)*DW +: DW]   = (b == 1) ? 64'hDEAD_BEEF : 64'h0;
    end
    start_run(6'b000100, '0, 1'b1);
    finish_run(1'b0);
    st_we = '0; st_addr = '0; st_din = '0;

    // watchdog fire: stage 0 never completes, timeout 5 -> error 6 cycles after start
    dly[0] = 0;
    @(posedge clk); #1;
    c0 = cyc;
    stage_en    = 6'b000011;
    timeout_cyc = TW'(5);
    start       = 1'b1;
    push(0, (32'd1 << 4) | 32'd0, c0 + 1);
    push(2, 32'd0, c0 + 6);
    finish_run(1'b1);

    // watchdog tie: done on the 5th run cycle with timeout 5 advances normally
    for (int s = 0; s < NS; s++) dly[s] = 4;
    start_run(6'b000011, TW'(5), 1'b0);
    finish_run(1'b0);

    // empty mask: done one cycle after start, no stage ever started
    start_run(6'b000000, '0, 1'b0);
    finish_run(1'b0);

    // reset during stage 3, then a fresh run from stage 0
    for (int s = 0; s < NS; s++) dly[s] = 3;
    dly[3] = 0;
    @(posedge clk); #1;
    c0 = cyc;
    stage_en    = 6'b111111;
    timeout_cyc = '0;
    start       = 1'b1;
    for (int s = 0; s < 4; s++) push(0, (32'd1 << (4 + s)) | 32'(s), c0 + 1 + 5*s);
    while (cyc < c0 + 18) begin @(posedge clk); #1; end
    rst   = 1'b1;
    start = 1'b0;
    push(6, 32'd0, cyc + 1);
    @(posedge clk); #1;
    rst = 1'b0;
    dly[3] = 3;
    start_run(6'b111111, '0, 1'b0);
    finish_run(1'b0);

    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events: got %0d events never observed, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
